// File: rtl/player_controller_p_if.sv
// Button/strobe inputs and packed entity outputs of player_controller_p.
// The slave modport is the controller's view; master is the decoder/pipeline view.
interface player_controller_p_if #(
  parameter int unsigned COORD_W  = 4,
  parameter int unsigned HEALTH_W = 2
);
  logic                   frame_tick;
  logic                   A;
  logic                   B;
  logic                   up;
  logic                   down;
  logic                   left;
  logic                   right;
  logic                   hit;
  logic [6+2*COORD_W-1:0] player;
  logic [6+2*COORD_W-1:0] sword;
  logic [HEALTH_W-1:0]    player_health;
  logic                   invulnerable;
  logic                   dead;

  modport slave (
    input  frame_tick, A, B, up, down, left, right, hit,
    output player, sword, player_health, invulnerable, dead
  );

  modport master (
    output frame_tick, A, B, up, down, left, right, hit,
    input  player, sword, player_health, invulnerable, dead
  );
endinterface

// File: rtl/player_controller_p.sv
// Tile-grid player: movement, sword attacks, damage/i-frames and death, advancing on frame_tick.
// Define PLAYER_KNOCKBACK_EN to push the player back one tile on each accepted hit.
module player_controller_p #(
  parameter int unsigned GRID_W        = 16,
  parameter int unsigned GRID_H        = 12,
  parameter int unsigned COORD_W       = 4,
  parameter int unsigned START_X       = 7,
  parameter int unsigned START_Y       = 5,
  parameter int unsigned MAX_HEALTH    = 3,
  parameter int unsigned HEALTH_W      = 2,
  parameter int unsigned MOVE_DELAY    = 4,
  parameter int unsigned SWORD_FRAMES  = 3,
  parameter int unsigned INVULN_FRAMES = 8
) (
  input logic                  clk,
  input logic                  reset,
  player_controller_p_if.slave bus
);

  localparam int unsigned WordW  = 6 + 2 * COORD_W;
  localparam int unsigned MoveW  = $clog2(MOVE_DELAY + 1);
  localparam int unsigned SwordW = $clog2(SWORD_FRAMES + 1);
  localparam int unsigned InvW   = $clog2(INVULN_FRAMES + 1);
  localparam logic [WordW-1:0] SwordHidden = {4'b1111, 2'b01, {(2 * COORD_W){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAttack, StDead} state_e;

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [1:0]          orient_q, orient_d;
  logic [WordW-1:0]    sword_q, sword_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [MoveW-1:0]    move_cnt_q, move_cnt_d;
  logic [SwordW-1:0]   sword_cnt_q, sword_cnt_d;
  logic [InvW-1:0]     inv_cnt_q, inv_cnt_d;

  // Returns {in_grid, x, y} of the tile adjacent in direction dir; never wraps.
  function automatic logic [2*COORD_W:0] step_tile(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y,
                                                   input logic [1:0]         dir);
    logic               ok;
    logic [COORD_W-1:0] nx, ny;
    ok = 1'b0;
    nx = x;
    ny = y;
    unique case (dir)
      2'b00: if (y != '0) begin ok = 1'b1; ny = y - COORD_W'(1); end
      2'b01: if (x < COORD_W'(GRID_W - 1)) begin ok = 1'b1; nx = x + COORD_W'(1); end
      2'b10: if (y < COORD_W'(GRID_H - 1)) begin ok = 1'b1; ny = y + COORD_W'(1); end
      default: if (x != '0) begin ok = 1'b1; nx = x - COORD_W'(1); end
    endcase
    return {ok, nx, ny};
  endfunction

  logic                 dir_any;
  logic [1:0]           dir_btn, act_dir;
  logic [2*COORD_W:0]   fwd;
  logic                 hit_ok;

  assign dir_any = bus.up | bus.down | bus.left | bus.right;
  assign dir_btn = bus.up ? 2'b00 : bus.down ? 2'b10 : bus.left ? 2'b11 : 2'b01;
  // Attacks with no direction pressed strike the way the player already faces.
  assign act_dir = dir_any ? dir_btn : orient_q;
  assign fwd     = step_tile(x_q, y_q, act_dir);
  assign hit_ok  = bus.frame_tick & bus.hit & (inv_cnt_q == '0) & (health_q != '0) &
                   (state_q != StDead);

`ifdef PLAYER_KNOCKBACK_EN
  logic [2*COORD_W:0] back;
  assign back = step_tile(x_q, y_q, orient_q ^ 2'b10);
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    orient_d    = orient_q;
    sword_d     = sword_q;
    health_d    = health_q;
    move_cnt_d  = move_cnt_q;
    sword_cnt_d = sword_cnt_q;
    inv_cnt_d   = inv_cnt_q;
    if (bus.frame_tick && state_q != StDead) begin
      if (move_cnt_q != '0) move_cnt_d = move_cnt_q - MoveW'(1);
      if (hit_ok) begin
        health_d  = health_q - HEALTH_W'(1);
        inv_cnt_d = InvW'(INVULN_FRAMES);
      end else if (inv_cnt_q != '0) begin
        inv_cnt_d = inv_cnt_q - InvW'(1);
      end
      if (health_q == '0) begin
        state_d = StDead;
        sword_d = SwordHidden;
      end else if (state_q == StAttack) begin
        if (sword_cnt_q == '0) begin
          state_d = StIdle;
          sword_d = SwordHidden;
        end else begin
          sword_cnt_d = sword_cnt_q - SwordW'(1);
        end
      end else if (bus.A || bus.B) begin
        state_d     = StAttack;
        orient_d    = act_dir;
        sword_d     = fwd[2*COORD_W] ? {4'b0001, act_dir, fwd[2*COORD_W-1:0]} : SwordHidden;
        sword_cnt_d = SwordW'(SWORD_FRAMES - 1);
      end else if (dir_any && move_cnt_q == '0) begin
        orient_d   = act_dir;
        move_cnt_d = MoveW'(MOVE_DELAY);
        if (fwd[2*COORD_W]) begin
          x_d = fwd[2*COORD_W-1:COORD_W];
          y_d = fwd[COORD_W-1:0];
        end
      end
`ifdef PLAYER_KNOCKBACK_EN
      // Knockback owns the position on a hit tick, even if the push is blocked.
      if (hit_ok) begin
        x_d = back[2*COORD_W] ? back[2*COORD_W-1:COORD_W] : x_q;
        y_d = back[2*COORD_W] ? back[COORD_W-1:0] : y_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      x_q         <= COORD_W'(START_X);
      y_q         <= COORD_W'(START_Y);
      orient_q    <= 2'b01;
      sword_q     <= SwordHidden;
      health_q    <= HEALTH_W'(MAX_HEALTH);
      move_cnt_q  <= '0;
      sword_cnt_q <= '0;
      inv_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      orient_q    <= orient_d;
      sword_q     <= sword_d;
      health_q    <= health_d;
      move_cnt_q  <= move_cnt_d;
      sword_cnt_q <= sword_cnt_d;
      inv_cnt_q   <= inv_cnt_d;
    end
  end

  assign bus.player        = {4'b0010, orient_q, x_q, y_q};
  assign bus.sword         = sword_q;
  assign bus.player_health = health_q;
  assign bus.invulnerable  = (inv_cnt_q != '0);
  assign bus.dead          = (state_q == StDead);

endmodule
